// File: rtl/elevator_control.sv
// Single-car elevator controller: decides door opening and single-floor moves,
// serving requests in the current direction of travel before reversing.
module elevator_control (
  input  logic clk,
  input  logic rst_n,
  input  logic request_i,
  input  logic request_j_gt_i,
  input  logic request_j_lt_i,
  input  logic close,
  output logic open,
  output logic up,
  output logic down
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DOOR_OPEN = 3'd1,
    DOOR_BUSY = 3'd2,
    MOVE_UP   = 3'd3,
    MOVE_DOWN = 3'd4
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  state_e state_q, state_d;
  dir_e   dir_q, dir_d;
  logic   open_q, open_d;
  logic   up_q, up_d;
  logic   down_q, down_d;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (request_i) begin
          state_d = DOOR_OPEN;
        end else if (dir_q == DIR_UP && request_j_gt_i) begin
          state_d = MOVE_UP;
        end else if (dir_q == DIR_DOWN && request_j_lt_i) begin
          state_d = MOVE_DOWN;
        end else if (request_j_gt_i) begin
          state_d = MOVE_UP;
          dir_d   = DIR_UP;
        end else if (request_j_lt_i) begin
          state_d = MOVE_DOWN;
          dir_d   = DIR_DOWN;
        end
      end
      DOOR_OPEN: if (!close) state_d = DOOR_BUSY;
      DOOR_BUSY: if (close)  state_d = IDLE;
      MOVE_UP:   state_d = IDLE;
      MOVE_DOWN: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    open_d = (state_d == DOOR_OPEN);
    up_d   = (state_d == MOVE_UP);
    down_d = (state_d == MOVE_DOWN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      open_q  <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      open_q  <= open_d;
      up_q    <= up_d;
      down_q  <= down_d;
    end
  end

  assign open = open_q;
  assign up   = up_q;
  assign down = down_q;

endmodule

// File: tb/tb_elevator_control.sv
// Directed self-checking bench for elevator_control.
module tb_elevator_control;

  logic clk;
  logic rst_n;
  logic request_i;
  logic request_j_gt_i;
  logic request_j_lt_i;
  logic close;
  logic open;
  logic up;
  logic down;

  int checks;
  int errors;
  logic prev_mv;

  elevator_control dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .request_i      (request_i),
    .request_j_gt_i (request_j_gt_i),
    .request_j_lt_i (request_j_lt_i),
    .close          (close),
    .open           (open),
    .up             (up),
    .down           (down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every-cycle invariants, sampled on the falling edge.
  initial prev_mv = 1'b0;
  always @(negedge clk) begin
    checks = checks + 1;
    if ($countones({open, up, down}) > 1) begin
      errors = errors + 1;
      $display("FAIL onehot t=%0t open=%b up=%b down=%b expected at most one high",
               $time, open, up, down);
    end
    checks = checks + 1;
    if ((up || down) && prev_mv) begin
      errors = errors + 1;
      $display("FAIL move_pulse_width t=%0t up=%b down=%b expected move pulse of one cycle",
               $time, up, down);
    end
    prev_mv = up | down;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic eo, input logic eu, input logic ed);
    // kept local to each scenario call site via name; compares all three outputs
    checks = checks + 1;
    if ({open, up, down} !== {eo, eu, ed}) begin
      errors = errors + 1;
      $display("FAIL %s open/up/down=%b%b%b expected %b%b%b",
               name, open, up, down, eo, eu, ed);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    request_i = 1'b0;
    request_j_gt_i = 1'b0;
    request_j_lt_i = 1'b0;
    close = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if ({open, up, down} !== 3'b000) begin
      errors = errors + 1;
      $display("FAIL reset_outputs got %b%b%b expected 000", open, up, down);
    end
    tick();
    checks = checks + 1;
    if ({open, up, down} !== 3'b000) begin
      errors = errors + 1;
      $display("FAIL reset_held got %b%b%b expected 000", open, up, down);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks = checks + 1;
      if ({open, up, down} !== 3'b000) begin
        errors = errors + 1;
        $display("FAIL idle_cycle%0d got %b%b%b expected 000", i, open, up, down);
      end
    end
  endtask

  task automatic test_door_first();
    request_i = 1'b1;
    request_j_gt_i = 1'b1;
    tick();
    expect_out("door_first_open", 1'b1, 1'b0, 1'b0);
    request_i = 1'b0;
    tick();
    expect_out("door_wait_ack", 1'b1, 1'b0, 1'b0);
    close = 1'b0;
    tick();
    expect_out("door_busy", 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("door_busy_hold", 1'b0, 1'b0, 1'b0);
    close = 1'b1;
    tick();
    expect_out("door_back_idle", 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("up_after_door", 1'b0, 1'b1, 1'b0);
    request_j_gt_i = 1'b0;
    tick();
    expect_out("up_one_cycle", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_direction();
    request_j_gt_i = 1'b1;
    request_j_lt_i = 1'b1;
    tick();
    expect_out("dir_up_pref1", 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("dir_idle_between", 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("dir_up_pref2", 1'b0, 1'b1, 1'b0);
    request_j_gt_i = 1'b0;
    tick();
    expect_out("dir_idle_reverse", 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("dir_reverse_down", 1'b0, 1'b0, 1'b1);
    request_j_gt_i = 1'b1;
    tick();
    expect_out("dir_idle_both", 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("dir_down_pref", 1'b0, 1'b0, 1'b1);
    request_j_gt_i = 1'b0;
    request_j_lt_i = 1'b0;
    tick();
    expect_out("dir_settle", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_door_hold();
    request_i = 1'b1;
    tick();
    expect_out("hold_open", 1'b1, 1'b0, 1'b0);
    request_i = 1'b0;
    request_j_gt_i = 1'b1;
    request_j_lt_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks = checks + 1;
      if ({open, up, down} !== 3'b100) begin
        errors = errors + 1;
        $display("FAIL hold_cycle%0d got %b%b%b expected 100", i, open, up, down);
      end
    end
    request_j_gt_i = 1'b0;
    request_j_lt_i = 1'b0;
    close = 1'b0;
    tick();
    expect_out("hold_busy", 1'b0, 1'b0, 1'b0);
    close = 1'b1;
    tick();
    expect_out("hold_idle", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_move();
    // direction is DOWN here; reset must restore UP preference
    request_j_lt_i = 1'b1;
    tick();
    expect_out("rst_pre_down", 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    expect_out("rst_mid_down", 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    request_j_gt_i = 1'b1;
    tick();
    expect_out("rst_dir_up", 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    expect_out("rst_mid_up", 1'b0, 1'b0, 1'b0);
    request_j_gt_i = 1'b0;
    request_j_lt_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    expect_out("rst_after_release", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_idle();
    test_door_first();
    test_direction();
    test_door_hold();
    test_reset_mid_move();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
